// File: rtl/arm_cond_stage_if.sv
// Handshake bundle for arm_cond_stage: upstream instruction port and downstream execute-enable port.
// The slave modport is the stage's view; master is the view of the logic that drives it.
interface arm_cond_stage_if #(
   parameter int TAG_W = 8
) ();
   logic             IN_VALID;
   logic             IN_READY;
   logic [3:0]       IN_COND;
   logic [TAG_W-1:0] IN_TAG;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic             OUT_EXEC;
   logic [TAG_W-1:0] OUT_TAG;

   modport slave (
      input  IN_VALID, IN_COND, IN_TAG, OUT_READY,
      output IN_READY, OUT_VALID, OUT_EXEC, OUT_TAG
   );

   modport master (
      output IN_VALID, IN_COND, IN_TAG, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_EXEC, OUT_TAG
   );
endinterface

// File: rtl/arm_cond_stage.sv
// Registered ARM condition-evaluation stage: NZCV flag register, single-entry pipeline slot, squash counter.
// Define ARM_COND_NV_EN to make cond 4'hF "never"; otherwise it behaves as "always".
module arm_cond_stage #(
   parameter int         TAG_W    = 8,
   parameter int         CNT_W    = 16,
   parameter logic [3:0] NZCV_RST = 4'b0000
) (
   input  logic                 CLK,
   input  logic                 RST,
   arm_cond_stage_if.slave      bus,
   input  logic                 FLAG_WE,
   input  logic [3:0]           FLAG_IN,
   output logic [3:0]           FLAGS,
   output logic [CNT_W-1:0]     SQUASH_CNT
);

   logic             valid_q, valid_d;
   logic             exec_q, exec_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       in_ready;
   logic       accept;
   logic       out_hs;
   logic [3:0] eff_flags;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      logic r;
      {n, z, c, v} = f;
      r = 1'b1;
      case (cond)
         4'h0: r = z;
         4'h1: r = !z;
         4'h2: r = c;
         4'h3: r = !c;
         4'h4: r = n;
         4'h5: r = !n;
         4'h6: r = v;
         4'h7: r = !v;
         4'h8: r = c & !z;
         4'h9: r = !c | z;
         4'hA: r = (n == v);
         4'hB: r = (n != v);
         4'hC: r = !z & (n == v);
         4'hD: r = z | (n != v);
         4'hE: r = 1'b1;
`ifdef ARM_COND_NV_EN
         4'hF: r = 1'b0;
`else
         4'hF: r = 1'b1;
`endif
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   assign in_ready  = !valid_q | bus.OUT_READY;
   assign accept    = bus.IN_VALID & in_ready;
   assign out_hs    = valid_q & bus.OUT_READY;
   // A flag write in the same cycle as an accept must be seen by that instruction.
   assign eff_flags = FLAG_WE ? FLAG_IN : flags_q;

   always_comb begin
      valid_d = valid_q;
      exec_d  = exec_q;
      tag_d   = tag_q;
      flags_d = FLAG_WE ? FLAG_IN : flags_q;
      cnt_d   = cnt_q;
      if (accept) begin
         valid_d = 1'b1;
         tag_d   = bus.IN_TAG;
         exec_d  = cond_pass(bus.IN_COND, eff_flags);
      end else if (out_hs) begin
         valid_d = 1'b0;
      end
      if (out_hs && !exec_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         exec_q  <= 1'b0;
         tag_q   <= '0;
         flags_q <= NZCV_RST;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         exec_q  <= exec_d;
         tag_q   <= tag_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.OUT_VALID = valid_q;
   assign bus.OUT_EXEC  = exec_q;
   assign bus.OUT_TAG   = tag_q;
   assign FLAGS         = flags_q;
   assign SQUASH_CNT    = cnt_q;

endmodule
